disparity_stream_framer: RTL and testbench

DISPARITY_STREAM_FRAMER -- requirements
Module: disparity_stream_framer

---
 rtl/disparity_stream_framer.sv | 130 +++++++++++++
 tb/tb_disparity_stream_framer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/disparity_stream_framer.sv
// disparity_stream_framer: tags SGM disparity samples with sof/eol/eof and buffers them for a valid/ready sink.
// Latency 2 cycles (disp_valid -> m_valid) on an empty FIFO; optional DISP_EDGE_MASK_EN zeroes left-edge columns.
// No upstream backpressure: a sample hitting a full FIFO is dropped and the rest of that frame is skipped.
module disparity_stream_framer #(
  parameter int FRAME_WIDTH  = 272,
  parameter int FRAME_HEIGHT = 240,
  parameter int MAX_DISP     = 16,
  parameter int FIFO_DEPTH   = 512
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [5:0]                    disp_in,
  input  logic                          disp_valid,
  input  logic                          clr_overflow,
  output logic [5:0]                    m_data,
  output logic                          m_sof,
  output logic                          m_eol,
  output logic                          m_eof,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          frame_done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int XW = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
  localparam int YW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
`ifdef DISP_EDGE_MASK_EN
  localparam bit EDGE_MASK = 1'b1;
`else
  localparam bit EDGE_MASK = 1'b0;
`endif

  typedef enum logic {STREAM, RESYNC} state_t;
  state_t state, state_next;

  logic [XW-1:0] in_x;
  logic [YW-1:0] in_y;
  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          last_x, last_y, fifo_full, fifo_empty;
  logic          out_load, fifo_pop, fifo_push, drop;
  logic          wr_sof, wr_eol, wr_eof;
  logic [5:0]    wr_disp;

  assign last_x     = (in_x == XW'(FRAME_WIDTH - 1));
  assign last_y     = (in_y == YW'(FRAME_HEIGHT - 1));
  assign fifo_full  = (fifo_level == LW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_level == '0);
  assign out_load   = !m_valid || m_ready;
  assign fifo_pop   = out_load && !fifo_empty;
  assign wr_sof     = (in_x == '0) && (in_y == '0);
  assign wr_eol     = last_x;
  assign wr_eof     = last_x && last_y;
  // Columns left of MAX_DISP-1 have no full right-image search window.
  assign wr_disp    = (EDGE_MASK && (32'(in_x) < MAX_DISP - 1)) ? 6'd0 : disp_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= STREAM;
      in_x  <= '0;
      in_y  <= '0;
    end else begin
      state <= state_next;
      if (disp_valid) begin
        if (last_x) begin
          in_x <= '0;
          in_y <= last_y ? '0 : in_y + 1'b1;
        end else begin
          in_x <= in_x + 1'b1;
        end
      end
    end
  end

  // A pop in the same cycle frees a slot, so a full FIFO only drops without one.
  always_comb begin
    state_next = state;
    fifo_push  = 1'b0;
    drop       = 1'b0;
    if (disp_valid) begin
      case (state)
        STREAM: begin
          if (fifo_full && !fifo_pop) begin
            drop       = 1'b1;
            state_next = RESYNC;
          end else begin
            fifo_push = 1'b1;
          end
        end
        RESYNC: begin
          if (last_x && last_y) state_next = STREAM;
        end
        default: state_next = STREAM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) mem[wr_ptr] <= {wr_eof, wr_sof, wr_eol, wr_disp};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_sof      <= 1'b0;
      m_eol      <= 1'b0;
      m_eof      <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= fifo_level + LW'(fifo_push) - LW'(fifo_pop);
      if (out_load) begin
        m_valid <= !fifo_empty;
        if (!fifo_empty) {m_eof, m_sof, m_eol, m_data} <= mem[rd_ptr];
      end
      frame_done <= m_valid && m_ready && m_eof;
      if (drop) overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_disparity_stream_framer.sv
// Directed bench for disparity_stream_framer with a queue-based reference model checked every cycle.
module tb_disparity_stream_framer;
  localparam int W = 8, H = 4, MD = 4, DEPTH = 8;
  localparam int LW = $clog2(DEPTH) + 1;
`ifdef DISP_EDGE_MASK_EN
  localparam bit MASK = 1'b1;
`else
  localparam bit MASK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, disp_valid, clr_overflow, m_ready;
  logic [5:0]    disp_in, m_data;
  logic          m_sof, m_eol, m_eof, m_valid, overflow, frame_done;
  logic [LW-1:0] fifo_level;

  always #5 clk = ~clk;

  disparity_stream_framer #(
    .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .MAX_DISP(MD), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .disp_in(disp_in), .disp_valid(disp_valid),
    .clr_overflow(clr_overflow), .m_data(m_data), .m_sof(m_sof), .m_eol(m_eol),
    .m_eof(m_eof), .m_valid(m_valid), .m_ready(m_ready), .fifo_level(fifo_level),
    .overflow(overflow), .frame_done(frame_done)
  );

  typedef struct packed {logic eof; logic sof; logic eol; logic [5:0] d;} beat_t;

  // Reference model: pixel index, buffered samples, output slot, sticky flag.
  beat_t mq[$];
  beat_t mout;
  bit    mvld, movf, mfd, mskip;
  int    pix;

  beat_t log_b[$];
  int    log_c[$];
  int    tests = 0, fails = 0, cyc = 0, fd_cnt = 0, t0 = 0, n63 = 0;

  function automatic logic [5:0] exp_d(int x, logic [5:0] d);
    return (MASK && x < MD - 1) ? 6'd0 : d;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    bit    load, xfer;
    int    x, y;
    beat_t b;
    if (rst) begin
      mq.delete(); mvld = 0; mout = '0; movf = 0; mfd = 0; mskip = 0; pix = 0;
      return;
    end
    xfer = mvld && m_ready;
    load = !mvld || m_ready;
    mfd  = xfer && mout.eof;
    if (load) begin
      mvld = (mq.size() > 0);
      if (mvld) mout = mq.pop_front();
    end
    if (disp_valid) begin
      x = pix % W;
      y = pix / W;
      if (mskip) begin
        if (x == W - 1 && y == H - 1) mskip = 0;
      end else if (mq.size() == DEPTH) begin
        movf  = 1;
        mskip = 1;
      end else begin
        b.d   = exp_d(x, disp_in);
        b.sof = (pix == 0);
        b.eol = (x == W - 1);
        b.eof = (pix == W * H - 1);
        mq.push_back(b);
      end
      pix = (pix + 1) % (W * H);
    end
    if (clr_overflow && !(disp_valid && !mskip && movf && mq.size() == DEPTH && !load))
      ;
  endtask

  task automatic cycle(bit v, logic [5:0] d, bit r, bit c = 1'b0);
    bit ovf_before;
    disp_valid = v; disp_in = d; m_ready = r; clr_overflow = c;
    if (m_valid && r) begin
      log_b.push_back({m_eof, m_sof, m_eol, m_data});
      log_c.push_back(cyc);
    end
    @(posedge clk);
    ovf_before = movf;
    movf = 0;
    model_step();
    // A new drop this cycle always wins over a clear; otherwise clear or hold.
    if (!rst && !movf) movf = c ? 1'b0 : ovf_before;
    cyc++;
    @(negedge clk);
    chk("m_valid", m_valid, mvld);
    if (mvld) chk("beat", {m_eof, m_sof, m_eol, m_data}, mout);
    chk("fifo_level", fifo_level, mq.size());
    chk("overflow", overflow, movf);
    chk("frame_done", frame_done, mfd);
    if (frame_done) fd_cnt++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(0, 6'd0, 0);
    cycle(0, 6'd0, 0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; disp_valid = 0; disp_in = 0; m_ready = 0; clr_overflow = 0;
    @(negedge clk);
    do_reset();
    chk("rst_valid", m_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_outs", {m_eof, m_sof, m_eol, m_data, frame_done}, 0);

    // One full frame, continuous flow.
    log_b.delete(); log_c.delete(); fd_cnt = 0; t0 = cyc;
    for (int i = 0; i < 32; i++) cycle(1, 6'(i % 8), 1);
    for (int i = 0; i < 4; i++) cycle(0, 6'd0, 1);
    chk("t1_beats", log_b.size(), 32);
    if (log_b.size() == 32) begin
      chk("t1_first_latency", log_c[0] - t0, 2);
      for (int i = 0; i < 32; i++)
        chk("t1_beat", log_b[i], {i == 31, i == 0, (i % 8) == 7, exp_d(i % 8, 6'(i % 8))});
    end
    chk("t1_frame_done", fd_cnt, 1);
    chk("t1_ovf", overflow, 0);

    // Stall the sink until the FIFO is full, then overflow.
    for (int i = 1; i <= 9; i++) cycle(1, 6'(i), 0);
    chk("t2_level", fifo_level, 8);
    chk("t2_hold_valid", m_valid, 1);
    chk("t2_hold_data", m_data, exp_d(0, 6'd1));
    chk("t2_hold_sof", m_sof, 1);
    chk("t2_ovf_clear", overflow, 0);
    cycle(1, 6'd10, 0);
    chk("t2_ovf_set", overflow, 1);
    chk("t2_level_capped", fifo_level, 8);

    // Rest of the broken frame must vanish; the next frame starts clean.
    log_b.delete(); log_c.delete();
    for (int i = 10; i < 32; i++) cycle(1, 6'd63, 1);
    for (int i = 0; i < 32; i++) cycle(1, 6'(i), 1);
    for (int i = 0; i < 4; i++) cycle(0, 6'd0, 1);
    chk("t3_beats", log_b.size(), 41);
    n63 = 0;
    foreach (log_b[i]) if (log_b[i].d == 6'd63) n63++;
    chk("t3_no_stale", n63, 0);
    if (log_b.size() == 41) begin
      for (int i = 0; i < 9; i++) chk("t3_old_data", log_b[i].d, exp_d(i % 8, 6'(i + 1)));
      chk("t3_new_sof", log_b[9], {1'b0, 1'b1, 1'b0, 6'd0});
      chk("t3_last_eof", log_b[40], {1'b1, 1'b0, 1'b1, 6'd31});
    end
    cycle(0, 6'd0, 1, 1);
    chk("t3_ovf_cleared", overflow, 0);

    // Full FIFO with a simultaneous pop and push.
    for (int i = 0; i < 9; i++) cycle(1, 6'd7, 0);
    chk("t4_full", fifo_level, 8);
    cycle(1, 6'd7, 1);
    chk("t4_level_kept", fifo_level, 8);
    chk("t4_no_ovf", overflow, 0);
    for (int i = 0; i < 12; i++) cycle(0, 6'd0, 1);
    chk("t4_drained", fifo_level, 0);

    // Set beats clear in the same cycle; clear alone then works.
    for (int i = 0; i < 9; i++) cycle(1, 6'd7, 0);
    cycle(1, 6'd7, 0, 1);
    chk("t5_set_wins", overflow, 1);
    cycle(0, 6'd0, 0, 1);
    chk("t5_clear", overflow, 0);

    // Reset mid-frame with data buffered, then an edge-mask row.
    do_reset();
    chk("t6_flushed", fifo_level, 0);
    chk("t6_no_valid", m_valid, 0);
    log_b.delete(); log_c.delete();
    for (int i = 0; i < 8; i++) cycle(1, 6'd5, 1);
    for (int i = 0; i < 4; i++) cycle(0, 6'd0, 1);
    chk("t6_beats", log_b.size(), 8);
    if (log_b.size() == 8) begin
      chk("t6_sof", log_b[0].sof, 1);
      for (int i = 0; i < 8; i++) chk("t6_mask", log_b[i].d, (MASK && i < 3) ? 6'd0 : 6'd5);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
